vector_pic: RTL

Parametrised vectored interrupt controller replacing the two-input simple_pic next to the Zet CPU. Provides N edge-triggered channels, a fixed-priority fully nested in-service model, a software mask register and non-specific EOI over a 16-bit Wishbone I/O slave port. Drives the CPU intr line and returns a full 8-bit vector during the wb_tgc interrupt-acknowledge handshake.

---
 rtl/vector_pic.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vector_pic.sv
// Vectored interrupt controller for the Zet CPU: N edge-triggered channels with
// fixed priority, nested in-service tracking, a mask register and non-specific EOI.
module vector_pic #(
    parameter int          N_IRQ    = 8,
    parameter int          IID_W    = 3,
    parameter logic [7:0]  VEC_BASE = 8'h08
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [N_IRQ-1:0]  irq_i,
    output logic              intr_o,
    input  logic              inta_i,
    output logic [7:0]        vec_o,
    input  logic [1:0]        wb_adr_i,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [7:0] SPUR_VEC = VEC_BASE + 8'(N_IRQ - 1);

    logic [N_IRQ-1:0] irq_q, irq_d;
    logic [N_IRQ-1:0] irr_q, irr_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [N_IRQ-1:0] imr_q, imr_d;
    logic             inta_q, inta_d;
    logic             intr_q, intr_d;
    logic [7:0]       vec_q, vec_d;
    logic             ack_q, ack_d;
    logic [15:0]      dat_q, dat_d;
    logic [1:0]       state_q, state_d;

    logic [N_IRQ-1:0] pend, win_oh, isr_eoi, rd_val, take_mask;
    logic [IID_W-1:0] win, isr_low;
    logic             eligible, inta_rise, take, wb_req, eoi;
    logic             unused_dat;

    function automatic logic [IID_W-1:0] lowest_idx(input logic [N_IRQ-1:0] v);
        logic [IID_W-1:0] r;
        r = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) r = IID_W'(i);
        end
        return r;
    endfunction

    assign unused_dat = ^wb_dat_i[15:N_IRQ];

    assign pend      = irr_q & ~imr_q;
    assign win_oh    = pend & (~pend + N_IRQ'(1));
    assign win       = lowest_idx(pend);
    assign isr_low   = lowest_idx(isr_q);
    // A pending channel only preempts when strictly higher priority than everything in service.
    assign eligible  = (|pend) && ((isr_q == '0) || (win < isr_low));
    assign inta_rise = inta_i & ~inta_q;

    assign wb_req = wb_stb_i & wb_cyc_i & ~ack_q;
    assign eoi    = wb_req & wb_we_i & (wb_adr_i == 2'd3);

    always_comb begin
        state_d = state_q;
        intr_d  = intr_q;
        vec_d   = vec_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inta_rise) begin
                    vec_d   = SPUR_VEC;
                    intr_d  = 1'b0;
                    state_d = ST_ACK;
                end else if (eligible) begin
                    intr_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (inta_rise) begin
                    take    = eligible;
                    vec_d   = eligible ? (VEC_BASE + 8'(win)) : SPUR_VEC;
                    intr_d  = 1'b0;
                    state_d = ST_ACK;
                end else if (!eligible) begin
                    intr_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!inta_i) state_d = ST_IDLE;
            end
            default: begin
                intr_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        take_mask = take ? win_oh : '0;
        irq_d     = irq_i;
        inta_d    = inta_i;
        // Edge set is OR-ed last so it beats a same-cycle acknowledge clear.
        irr_d     = (irr_q & ~take_mask) | (irq_i & ~irq_q);
        // EOI retires the old in-service bit before a new acknowledge adds its own.
        isr_eoi   = eoi ? (isr_q & (isr_q - N_IRQ'(1))) : isr_q;
        isr_d     = isr_eoi | take_mask;
        imr_d     = imr_q;
        if (wb_req && wb_we_i && (wb_adr_i == 2'd1)) imr_d = wb_dat_i[N_IRQ-1:0];
    end

    always_comb begin
        case (wb_adr_i)
            2'd0:    rd_val = irr_q;
            2'd1:    rd_val = imr_q;
            2'd2:    rd_val = isr_q;
            default: rd_val = '0;
        endcase
        ack_d = wb_req;
        dat_d = wb_req ? {{(16 - N_IRQ){1'b0}}, rd_val} : 16'h0000;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_q   <= '1;
            irr_q   <= '0;
            isr_q   <= '0;
            imr_q   <= '0;
            inta_q  <= 1'b0;
            intr_q  <= 1'b0;
            vec_q   <= VEC_BASE;
            ack_q   <= 1'b0;
            dat_q   <= 16'h0000;
            state_q <= ST_IDLE;
        end else begin
            irq_q   <= irq_d;
            irr_q   <= irr_d;
            isr_q   <= isr_d;
            imr_q   <= imr_d;
            inta_q  <= inta_d;
            intr_q  <= intr_d;
            vec_q   <= vec_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            state_q <= state_d;
        end
    end

    assign intr_o   = intr_q;
    assign vec_o    = vec_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule
